mc_control_unit: RTL and testbench
==================================

# mc_control_unit

Multicycle control FSM that drives the datapath of the multicycle CPU, including the `PCSource` select of the PC-source multiplexer (`MXPCSource`) directly downstream. It decodes the 6-bit opcode from the instruction register and sequences fetch, decode, execute, memory and write-back states. It produces every datapath enable, including the combined PC write enable `PCEn`. A memory-ready handshake stretches the memory-access states.

## Interface
Parameters:
- `EXC_ON_ILLEGAL`, default 1: 1 = an unknown opcode enters state EXC; 0 = it returns to FETCH with no PC write.

Ports (`name  direction  width  meaning`):
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `Op`  in  6  opcode, IR[31:26]; stable after FETCH.
- `Zero`  in  1  ALU zero flag.
- `MemReady`  in  1  memory has completed the current access.
- `PCEn`  out  1  PC register load enable.
- `PCSource`  out  2  PC mux select: 00 ALU result (PC+4), 01 ALUOut (branch target), 10 jump target, 11 exception vector.
- `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `RegWrite`, `RegDst`, `ALUSrcA`  out  1 each  datapath controls.
- `ALUSrcB`  out  2  ALU operand-B select.
- `ALUOp`  out  2  ALU operation class.
- `Exc`  out  1  one-cycle illegal-opcode pulse.
- `State`  out  4  current state, for debug.

## Operation
- Moore FSM with a 4-bit state register. Outputs decode from the state; `PCEn`, `IRWrite` and `PCWrite` are additionally gated as described below.
- Encoding: RESET=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12, EXC=13. Codes 14–15 go to FETCH.
- Any output not listed for a state is 0. Outputs per state:
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite assert only when MemReady=1.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMRD: MemRead=1, IorD=1.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0.
  - MEMWR: MemWrite=1, IorD=1.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - ALUWB: RegWrite=1, RegDst=1.
  - ADDIWB: RegWrite=1, RegDst=0.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWriteCond=1.
  - JUMP: PCWrite=1, PCSource=10.
  - EXC: PCWrite=1, PCSource=11, Exc=1.
- `PCEn` = PCWrite | (PCWriteCond & (Zero ^ (Op==6'h05))). This covers beq (0x04) and bne (0x05).
- Transitions:
  - RESET→FETCH.
  - FETCH→DECODE when MemReady=1; otherwise hold.
  - DECODE by opcode: 0x23 or 0x2B→MEMADR; 0x00→EXEC; 0x04 or 0x05→BRANCH; 0x02→JUMP; 0x08→ADDIEX; any other opcode→EXC (or FETCH if EXC_ON_ILLEGAL=0).
  - MEMADR→MEMRD (0x23) or MEMWR (0x2B).
  - MEMRD→MEMWB when MemReady=1; otherwise hold.
  - MEMWR→FETCH when MemReady=1; otherwise hold.
  - EXEC→ALUWB; ADDIEX→ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP and EXC→FETCH.

## Timing
- Reset: when `rst_n`=0 at a rising edge, the state becomes RESET. In RESET every output is 0 and `State`=0.
- The first FETCH occurs on the first edge after `rst_n` returns to 1.
- Reset mid-instruction: the next edge forces RESET and aborts the instruction. No PC or register write occurs after that edge.
- Cycles per instruction with MemReady held at 1: lw 5; sw 4; R-type 4; addi 4; beq/bne 3; j 3; illegal 3.
- Each cycle of MemReady=0 in FETCH, MEMRD or MEMWR adds one cycle.
- While stalled in FETCH, PCEn=0 and IRWrite=0, so the PC advances exactly once per fetch.
- `Exc` is high for exactly one cycle per illegal opcode.
- `PCSource` is valid in the same cycle as `PCEn`. The PC loads on the edge that ends that cycle.

## Test plan
- Reset: hold `rst_n`=0 for 3 edges, with random Op, Zero and MemReady.
  - During reset: all outputs 0, State=0.
  - After release: State=1 on the first edge, with MemRead=1 and PCEn=1.
- lw (Op=0x23), MemReady=1:
  - State sequence 1,2,3,4,5,1.
  - MEMWB cycle: RegWrite=1, MemtoReg=1.
  - PCEn high only in FETCH.
- beq (Op=0x04):
  - Zero=1: BRANCH cycle gives PCEn=1, PCSource=01.
  - Zero=0: PCEn=0.
  - bne (Op=0x05): both results inverted.
- j (Op=0x02): State sequence 1,2,10,1; JUMP cycle has PCEn=1, PCSource=10.
- sw (Op=0x2B) with MemReady=0 for 2 cycles in FETCH and 3 cycles in MEMWR:
  - Total 9 cycles.
  - PCEn asserts exactly once.
  - MemWrite is high for 4 consecutive cycles.
- Illegal opcode Op=0x3F:
  - State sequence 1,2,13,1; Exc=1 for one cycle with PCSource=11 and PCEn=1.
  - With EXC_ON_ILLEGAL=0: sequence 2→1, and Exc is never asserted.

Source files
------------

// File: rtl/mc_control_unit_if.sv
// Control bus between the multicycle control FSM and the CPU datapath.
// master = controller side, slave = datapath side.
interface mc_control_unit_if;
  logic [5:0] Op;
  logic       Zero;
  logic       MemReady;
  logic       PCEn;
  logic [1:0] PCSource;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegWrite;
  logic       RegDst;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       Exc;
  logic [3:0] State;

  modport master (
    input  Op, Zero, MemReady,
    output PCEn, PCSource, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, Exc, State
  );

  modport slave (
    output Op, Zero, MemReady,
    input  PCEn, PCSource, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, Exc, State
  );
endinterface

// File: rtl/mc_control_unit.sv
// Moore control FSM for the multicycle CPU: fetch/decode/execute/memory/write-back
// sequencing, with MemReady stretching the memory-access states.
module mc_control_unit #(
  parameter bit EXC_ON_ILLEGAL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mc_control_unit_if.master    bus
);

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_JUMP   = 4'd10, S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12, S_EXC    = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_e     state_q, state_d;
  logic       pc_write, pc_write_cond;
  logic [1:0] pc_source;
  logic       iord, mem_read, mem_write, ir_write, memto_reg;
  logic       reg_write, reg_dst, alu_src_a, exc;
  logic [1:0] alu_src_b, alu_op;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_RESET;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    memto_reg     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    exc           = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // PC and IR load only on the cycle the fetch completes
        pc_write  = bus.MemReady;
        ir_write  = bus.MemReady;
        if (bus.MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (bus.Op)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYPE:       state_d = S_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_ADDI:        state_d = S_ADDIEX;
          default:        state_d = EXC_ON_ILLEGAL ? S_EXC : S_FETCH;
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (state_q == S_ADDIEX)   state_d = S_ADDIWB;
        else if (bus.Op == OP_SW)  state_d = S_MEMWR;
        else                       state_d = S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (bus.MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write = 1'b1;
        memto_reg = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (bus.MemReady) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_source     = 2'b01;
        pc_write_cond = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = S_FETCH;
      end
      S_EXC: begin
        pc_write  = 1'b1;
        pc_source = 2'b11;
        exc       = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // bne takes the branch on !Zero, beq on Zero
  assign bus.PCEn     = pc_write | (pc_write_cond & (bus.Zero ^ (bus.Op == OP_BNE)));
  assign bus.PCSource = pc_source;
  assign bus.IorD     = iord;
  assign bus.MemRead  = mem_read;
  assign bus.MemWrite = mem_write;
  assign bus.IRWrite  = ir_write;
  assign bus.MemtoReg = memto_reg;
  assign bus.RegWrite = reg_write;
  assign bus.RegDst   = reg_dst;
  assign bus.ALUSrcA  = alu_src_a;
  assign bus.ALUSrcB  = alu_src_b;
  assign bus.ALUOp    = alu_op;
  assign bus.Exc      = exc;
  assign bus.State    = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: per-cycle expected outputs go through a
// scoreboard queue; a second instance covers EXC_ON_ILLEGAL=0.
module tb_mc_control_unit;

  logic clk;
  logic rst_n;

  mc_control_unit_if bus1 ();
  mc_control_unit_if bus2 ();

  mc_control_unit #(.EXC_ON_ILLEGAL(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  mc_control_unit #(.EXC_ON_ILLEGAL(1'b0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  typedef struct packed {
    logic [3:0] st;
    logic       pcen;
    logic [1:0] src;
    logic       exc;
    logic       rd;
    logic       wr;
    logic       rw;
    logic       mtr;
    logic       ir;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  logic [5:0] cur_op = 6'h00;
  logic       next_rst = 1'b0;
  logic       win = 1'b0;
  int         cyc_cnt = 0, pcen_cnt = 0, memwr_cnt = 0;
  logic       exc2_seen = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (bus2.Exc === 1'b1) exc2_seen <= 1'b1;

  function automatic exp_t E(logic [3:0] st, logic pcen, logic [1:0] src, logic exc,
                             logic rd, logic wr, logic rw, logic mtr, logic ir);
    exp_t e;
    e = '{st, pcen, src, exc, rd, wr, rw, mtr, ir};
    return e;
  endfunction

  function automatic exp_t obs1();
    exp_t o;
    o = '{bus1.State, bus1.PCEn, bus1.PCSource, bus1.Exc, bus1.MemRead,
          bus1.MemWrite, bus1.RegWrite, bus1.MemtoReg, bus1.IRWrite};
    return o;
  endfunction

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then compare that cycle's outputs.
  task automatic step(logic mr, logic z, exp_t e, string tag);
    exp_t x;
    @(negedge clk);
    rst_n = next_rst;
    bus1.Op = cur_op;  bus2.Op = cur_op;
    bus1.MemReady = mr; bus2.MemReady = mr;
    bus1.Zero = z;      bus2.Zero = z;
    sb.push_back(e);
    #1;
    x = sb.pop_front();
    chk(tag, obs1(), x);
    if (win) begin
      cyc_cnt++;
      pcen_cnt  += int'(bus1.PCEn);
      memwr_cnt += int'(bus1.MemWrite);
    end
  endtask

  exp_t F1, F0, DEC;

  initial begin
    F1  = E(4'd1, 1, 2'd0, 0, 1, 0, 0, 0, 1);
    F0  = E(4'd1, 0, 2'd0, 0, 1, 0, 0, 0, 0);
    DEC = E(4'd2, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    bus1.Op = 6'h00; bus1.Zero = 1'b0; bus1.MemReady = 1'b0;
    bus2.Op = 6'h00; bus2.Zero = 1'b0; bus2.MemReady = 1'b0;
    @(posedge clk);

    // reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      cur_op = 6'($urandom_range(0, 63));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), E(0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_hold");
      chk("rst_outs", {bus1.PCEn, bus1.PCSource, bus1.IorD, bus1.MemRead, bus1.MemWrite,
                       bus1.IRWrite, bus1.MemtoReg, bus1.RegWrite, bus1.RegDst, bus1.ALUSrcA,
                       bus1.ALUSrcB, bus1.ALUOp, bus1.Exc, bus1.State}, 32'd0);
    end
    next_rst = 1'b1;
    step(1, 0, E(0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_release");

    // lw
    cur_op = 6'h23;
    step(1, 0, F1, "lw_fetch");
    step(1, 0, DEC, "lw_dec");
    chk("dec_alusrcb", {30'd0, bus1.ALUSrcB}, 32'd3);
    step(1, 0, E(4'd3, 0, 0, 0, 0, 0, 0, 0, 0), "lw_memadr");
    chk("memadr_alu", {bus1.ALUSrcA, bus1.ALUSrcB, bus1.ALUOp}, 32'b11000);
    step(1, 0, E(4'd4, 0, 0, 0, 1, 0, 0, 0, 0), "lw_memrd");
    chk("memrd_iord", {31'd0, bus1.IorD}, 32'd1);
    step(1, 0, E(4'd5, 0, 0, 0, 0, 0, 1, 1, 0), "lw_memwb");

    // beq / bne taken and not taken
    cur_op = 6'h04;
    step(1, 0, F1, "beq1_fetch"); step(1, 0, DEC, "beq1_dec");
    step(1, 1, E(4'd9, 1, 2'd1, 0, 0, 0, 0, 0, 0), "beq_zero1");
    chk("branch_aluop", {30'd0, bus1.ALUOp}, 32'd1);
    step(1, 0, F1, "beq0_fetch"); step(1, 0, DEC, "beq0_dec");
    step(1, 0, E(4'd9, 0, 2'd1, 0, 0, 0, 0, 0, 0), "beq_zero0");
    cur_op = 6'h05;
    step(1, 1, F1, "bne1_fetch"); step(1, 1, DEC, "bne1_dec");
    step(1, 1, E(4'd9, 0, 2'd1, 0, 0, 0, 0, 0, 0), "bne_zero1");
    step(1, 0, F1, "bne0_fetch"); step(1, 0, DEC, "bne0_dec");
    step(1, 0, E(4'd9, 1, 2'd1, 0, 0, 0, 0, 0, 0), "bne_zero0");

    // j
    cur_op = 6'h02;
    step(1, 0, F1, "j_fetch"); step(1, 0, DEC, "j_dec");
    step(1, 0, E(4'd10, 1, 2'd2, 0, 0, 0, 0, 0, 0), "j_jump");

    // R-type
    cur_op = 6'h00;
    step(1, 0, F1, "r_fetch"); step(1, 0, DEC, "r_dec");
    step(1, 0, E(4'd7, 0, 0, 0, 0, 0, 0, 0, 0), "r_exec");
    chk("exec_aluop", {bus1.ALUSrcA, bus1.ALUOp}, 32'b110);
    step(1, 0, E(4'd8, 0, 0, 0, 0, 0, 1, 0, 0), "r_aluwb");
    chk("aluwb_regdst", {31'd0, bus1.RegDst}, 32'd1);

    // addi
    cur_op = 6'h08;
    step(1, 0, F1, "addi_fetch"); step(1, 0, DEC, "addi_dec");
    step(1, 0, E(4'd11, 0, 0, 0, 0, 0, 0, 0, 0), "addi_ex");
    step(1, 0, E(4'd12, 0, 0, 0, 0, 0, 1, 0, 0), "addi_wb");

    // sw with stalls in FETCH and MEMWR
    cur_op = 6'h2B;
    win = 1'b1;
    step(0, 0, F0, "sw_fetch_stall0");
    step(0, 0, F0, "sw_fetch_stall1");
    step(1, 0, F1, "sw_fetch");
    step(1, 0, DEC, "sw_dec");
    step(1, 0, E(4'd3, 0, 0, 0, 0, 0, 0, 0, 0), "sw_memadr");
    for (int i = 0; i < 3; i++) step(0, 0, E(4'd6, 0, 0, 0, 0, 1, 0, 0, 0), "sw_memwr_stall");
    step(1, 0, E(4'd6, 0, 0, 0, 0, 1, 0, 0, 0), "sw_memwr");
    win = 1'b0;
    chk("sw_cycles", cyc_cnt, 32'd9);
    chk("sw_pcen_cnt", pcen_cnt, 32'd1);
    chk("sw_memwr_cnt", memwr_cnt, 32'd4);

    // reset mid-lw: MEMWB must never be reached
    cur_op = 6'h23;
    step(1, 0, F1, "abort_fetch"); step(1, 0, DEC, "abort_dec");
    step(1, 0, E(4'd3, 0, 0, 0, 0, 0, 0, 0, 0), "abort_memadr");
    next_rst = 1'b0;
    step(1, 0, E(4'd4, 0, 0, 0, 1, 0, 0, 0, 0), "abort_memrd");
    next_rst = 1'b1;
    step(1, 0, E(0, 0, 0, 0, 0, 0, 0, 0, 0), "abort_reset");

    // illegal opcode, both parameterisations
    cur_op = 6'h3F;
    step(1, 0, F1, "ill_fetch");
    step(1, 0, DEC, "ill_dec");
    chk("ill2_dec_state", {28'd0, bus2.State}, 32'd2);
    step(1, 0, E(4'd13, 1, 2'd3, 1, 0, 0, 0, 0, 0), "ill_exc");
    chk("ill2_state", {28'd0, bus2.State}, 32'd1);
    cur_op = 6'h00;
    step(1, 0, F1, "ill_next_fetch");
    chk("ill2_no_exc", {31'd0, exc2_seen}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
